// File: rtl/ysyx_squ.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// ysyx_squ : store queue unit
//
// Buffers committed stores in program order and drains them one at a time to
// the data-memory write channel (request, then response). Committed stores are
// architectural state, so nothing but reset discards queue contents.
//
// Ports
//   clock, reset       : system clock, synchronous active-high reset
//   cm_*               : commit port from the reorder unit (valid, store, size
//                        code, byte address, right-aligned data, pc)
//   sq_ready           : queue can accept one store this cycle (registered state)
//   sq_empty           : no entry held and drain FSM idle (fence wait)
//   mem_aw*/mem_w*     : write request, held stable while mem_awready is low
//   mem_bvalid         : write response, always accepted
//   ld_addr/ld_conflict: load probe; conflict when a held store hits the word
//   dbg_pc             : pc of the entry at the head of the queue
// ----------------------------------------------------------------------------
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
`ifndef YSYX_WSTRB_SB
`define YSYX_WSTRB_SB 5'h01
`endif
`ifndef YSYX_WSTRB_SH
`define YSYX_WSTRB_SH 5'h03
`endif
`ifndef YSYX_WSTRB_SW
`define YSYX_WSTRB_SW 5'h0F
`endif

module ysyx_squ #(
   parameter int SQ_SIZE = 4,
   parameter int XLEN    = `YSYX_XLEN
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            cm_valid,
   input  logic            cm_store,
   input  logic [4:0]      cm_alu,
   input  logic [XLEN-1:0] cm_waddr,
   input  logic [XLEN-1:0] cm_wdata,
   input  logic [XLEN-1:0] cm_pc,
   output logic            sq_ready,
   output logic            sq_empty,
   output logic            mem_awvalid,
   output logic [XLEN-1:0] mem_awaddr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [3:0]      mem_wstrb,
   input  logic            mem_awready,
   input  logic            mem_bvalid,
   input  logic [XLEN-1:0] ld_addr,
   output logic            ld_conflict,
   output logic [XLEN-1:0] dbg_pc
);

   localparam int        AW     = $clog2(SQ_SIZE);
   localparam logic [AW:0] L_FULL = SQ_SIZE[AW:0];

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   state_t              r_state;
   logic [AW-1:0]       r_head;
   logic [AW-1:0]       r_tail;
   logic [AW:0]         r_count;
   logic [SQ_SIZE-1:0]  r_valid;
   logic [XLEN-1:0]     r_addr [SQ_SIZE];
   logic [XLEN-1:0]     r_data [SQ_SIZE];
   logic [3:0]          r_strb [SQ_SIZE];
   logic [XLEN-1:0]     r_pc   [SQ_SIZE];

   logic                r_awvalid;
   logic [XLEN-1:0]     r_awaddr;
   logic [XLEN-1:0]     r_wdata;
   logic [3:0]          r_wstrb;

   logic                w_enq;
   logic                w_pop;
   logic [XLEN-1:0]     w_new_addr;
   logic [XLEN-1:0]     w_new_data;
   logic [3:0]          w_new_strb;
   logic                w_conflict;

   assign sq_ready = (r_count != L_FULL);
   assign w_enq    = cm_valid && cm_store && sq_ready;
   assign w_pop    = (r_state == S_RESP) && mem_bvalid;

   assign w_new_addr = {cm_waddr[XLEN-1:2], 2'b00};

   // Size decode: replicate the low bytes across all lanes so the strobe
   // alone selects the written lane.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path through the case leaves it unassigned (that would infer a latch).
      w_new_data = cm_wdata;
      w_new_strb = 4'b0000;
      case (cm_alu)
         `YSYX_WSTRB_SB: begin
            w_new_strb = 4'b0001 << cm_waddr[1:0];
            w_new_data = {(XLEN/8){cm_wdata[7:0]}};
         end
         `YSYX_WSTRB_SH: begin
            w_new_strb = 4'b0011 << cm_waddr[1:0];
            w_new_data = {(XLEN/16){cm_wdata[15:0]}};
         end
         `YSYX_WSTRB_SW: begin
            w_new_strb = 4'b1111;
         end
         default: ;
      endcase
   end

   // Entry payload. Contents are only ever observed through a set valid bit,
   // so the arrays need no reset.
   // NOTE: data arrays are deliberately left out of reset; the valid bits gate
   // every read, and resetting storage would only add reset fan-out.
   always_ff @(posedge clock) begin
      if (w_enq) begin
         r_addr[r_tail] <= w_new_addr;
         r_data[r_tail] <= w_new_data;
         r_strb[r_tail] <= w_new_strb;
         r_pc[r_tail]   <= cm_pc;
      end
   end

   // Pointers, occupancy, valid bits and the drain FSM with registered outputs.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before this edge, independent of statement order.
      if (reset) begin
         r_state   <= S_IDLE;
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_valid   <= '0;
         r_awvalid <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else begin
         if (w_enq) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + 1'b1;
         end
         // Head and tail never coincide when both fire: a pop needs an entry
         // and an enqueue needs a free slot.
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + 1'b1;
         end
         if (w_enq && !w_pop)
            r_count <= r_count + 1'b1;
         else if (w_pop && !w_enq)
            r_count <= r_count - 1'b1;

         case (r_state)
            S_IDLE: begin
               if (r_valid[r_head]) begin
                  r_state   <= S_REQ;
                  r_awvalid <= 1'b1;
                  r_awaddr  <= r_addr[r_head];
                  r_wdata   <= r_data[r_head];
                  r_wstrb   <= r_strb[r_head];
               end else if (w_enq) begin
                  // Empty queue: the incoming store is the head, so present
                  // it directly and save a cycle of drain latency.
                  r_state   <= S_REQ;
                  r_awvalid <= 1'b1;
                  r_awaddr  <= w_new_addr;
                  r_wdata   <= w_new_data;
                  r_wstrb   <= w_new_strb;
               end
            end
            S_REQ: begin
               if (mem_awready) begin
                  r_state   <= S_RESP;
                  r_awvalid <= 1'b0;
               end
            end
            S_RESP: begin
               if (mem_bvalid)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Load probe: any held store on the same word, including the one draining.
   always_comb begin
      w_conflict = 1'b0;
      for (int i = 0; i < SQ_SIZE; i++) begin
         if (r_valid[i] && (r_addr[i][XLEN-1:2] == ld_addr[XLEN-1:2]))
            w_conflict = 1'b1;
      end
   end

   assign ld_conflict = w_conflict;
   assign sq_empty    = (r_count == '0) && (r_state == S_IDLE);
   assign mem_awvalid = r_awvalid;
   assign mem_awaddr  = r_awaddr;
   assign mem_wdata   = r_wdata;
   assign mem_wstrb   = r_wstrb;
   assign dbg_pc      = r_valid[r_head] ? r_pc[r_head] : '0;

endmodule

// File: tb/tb_ysyx_squ.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_ysyx_squ : self-checking bench for the store queue unit.
// A table of single stores is applied with an always-ready bus; hand-written
// sequences cover back-pressure with a full queue, the load probe, and reset
// during an outstanding response. A negedge bus model records every accepted
// write, which is compared in order against the expected-write queue.
// ----------------------------------------------------------------------------
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
`ifndef YSYX_WSTRB_SB
`define YSYX_WSTRB_SB 5'h01
`endif
`ifndef YSYX_WSTRB_SH
`define YSYX_WSTRB_SH 5'h03
`endif
`ifndef YSYX_WSTRB_SW
`define YSYX_WSTRB_SW 5'h0F
`endif

module tb_ysyx_squ;

   logic        clock = 1'b0;
   logic        reset;
   logic        cm_valid, cm_store;
   logic [4:0]  cm_alu;
   logic [31:0] cm_waddr, cm_wdata, cm_pc;
   logic        sq_ready, sq_empty;
   logic        mem_awvalid;
   logic [31:0] mem_awaddr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_awready = 1'b0;
   logic        mem_bvalid  = 1'b0;
   logic [31:0] ld_addr;
   logic        ld_conflict;
   logic [31:0] dbg_pc;

   ysyx_squ #(.SQ_SIZE(4), .XLEN(32)) dut (
      .clock(clock), .reset(reset),
      .cm_valid(cm_valid), .cm_store(cm_store), .cm_alu(cm_alu),
      .cm_waddr(cm_waddr), .cm_wdata(cm_wdata), .cm_pc(cm_pc),
      .sq_ready(sq_ready), .sq_empty(sq_empty),
      .mem_awvalid(mem_awvalid), .mem_awaddr(mem_awaddr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_awready(mem_awready), .mem_bvalid(mem_bvalid),
      .ld_addr(ld_addr), .ld_conflict(ld_conflict), .dbg_pc(dbg_pc)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } wr_t;

   typedef struct {
      logic [4:0]  alu;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
      logic [3:0]  exp_strb;
   } vec_t;

   wr_t exp_q[$];
   wr_t obs_q[$];

   int checks = 0;
   int errors = 0;

   // Bus model controls (written by the main process only).
   logic bus_en  = 1'b0;
   logic aw_ok   = 1'b0;
   logic force_b = 1'b0;
   int   b_delay = 0;

   // Bus model state (written by the bus model only).
   logic pend = 1'b0;
   int   bcnt = 0;

   always @(negedge clock) begin
      if (!bus_en) begin
         mem_awready = 1'b0;
         mem_bvalid  = force_b;
         pend        = 1'b0;
      end else begin
         mem_awready = aw_ok;
         mem_bvalid  = 1'b0;
         if (mem_awvalid && mem_awready) begin
            obs_q.push_back('{mem_awaddr, mem_wdata, mem_wstrb});
            pend = 1'b1;
            bcnt = b_delay;
         end else if (pend) begin
            if (bcnt == 0) begin
               mem_bvalid = 1'b1;
               pend       = 1'b0;
            end else begin
               bcnt = bcnt - 1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One commit-port store; the expected bus write goes to the scoreboard.
   task automatic enq(input logic [4:0] alu, input logic [31:0] addr,
                      input logic [31:0] data, input logic [31:0] pc,
                      input wr_t e);
      int n = 0;
      while (!sq_ready && n < 20) begin
         tick();
         n++;
      end
      check_bit("ready_before_enq", sq_ready, 1'b1);
      cm_valid = 1'b1;
      cm_store = 1'b1;
      cm_alu   = alu;
      cm_waddr = addr;
      cm_wdata = data;
      cm_pc    = pc;
      exp_q.push_back(e);
      tick();
      cm_valid = 1'b0;
      cm_store = 1'b0;
   endtask

   // Compare every recorded bus write against the expected queue, in order.
   task automatic sb_check();
      wr_t o, e;
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         if (exp_q.size() == 0) begin
            check("sb_extra_write", o.addr, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("sb_awaddr", o.addr, e.addr);
            check("sb_wdata", o.data, e.data);
            check("sb_wstrb", {28'd0, o.strb}, {28'd0, e.strb});
         end
      end
      check("sb_outstanding", exp_q.size(), 0);
   endtask

   task automatic wait_empty(input int max_cycles);
      int n = 0;
      while (!sq_empty && n < max_cycles) begin
         tick();
         n++;
      end
      check_bit("drain_done", sq_empty, 1'b1);
   endtask

   vec_t vecs[5];

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{`YSYX_WSTRB_SW, 32'h8000_0004, 32'h1122_3344, 32'h8000_0004, 32'h1122_3344, 4'b1111};
      vecs[1] = '{`YSYX_WSTRB_SB, 32'h8000_0003, 32'h0000_00AB, 32'h8000_0000, 32'hABAB_ABAB, 4'b1000};
      vecs[2] = '{`YSYX_WSTRB_SH, 32'h8000_0002, 32'h0000_BEEF, 32'h8000_0000, 32'hBEEF_BEEF, 4'b1100};
      vecs[3] = '{`YSYX_WSTRB_SB, 32'h8000_0101, 32'h1234_5655, 32'h8000_0100, 32'h5555_5555, 4'b0010};
      vecs[4] = '{`YSYX_WSTRB_SH, 32'h8000_0040, 32'hFFFF_1357, 32'h8000_0040, 32'h1357_1357, 4'b0011};

      reset    = 1'b1;
      cm_valid = 1'b0;
      cm_store = 1'b0;
      cm_alu   = '0;
      cm_waddr = '0;
      cm_wdata = '0;
      cm_pc    = '0;
      ld_addr  = 32'h8000_0004;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // Reset state.
      check_bit("rst_ready", sq_ready, 1'b1);
      check_bit("rst_empty", sq_empty, 1'b1);
      check_bit("rst_awvalid", mem_awvalid, 1'b0);
      check("rst_awaddr", mem_awaddr, 32'h0);
      check_bit("rst_conflict", ld_conflict, 1'b0);
      check("rst_dbg_pc", dbg_pc, 32'h0);

      // A retiring non-store must not enqueue.
      cm_valid = 1'b1;
      cm_store = 1'b0;
      tick();
      cm_valid = 1'b0;
      check_bit("nonstore_empty", sq_empty, 1'b1);
      tick();
      check_bit("nonstore_awvalid", mem_awvalid, 1'b0);

      // Table: single stores with an always-ready bus.
      bus_en  = 1'b1;
      aw_ok   = 1'b1;
      b_delay = 0;
      for (int i = 0; i < 5; i++) begin
         enq(vecs[i].alu, vecs[i].addr, vecs[i].data, 32'h0000_0100 + i,
             '{vecs[i].exp_addr, vecs[i].exp_data, vecs[i].exp_strb});
         check_bit("tbl_awvalid", mem_awvalid, 1'b1);
         check("tbl_awaddr", mem_awaddr, vecs[i].exp_addr);
         check("tbl_wdata", mem_wdata, vecs[i].exp_data);
         check("tbl_wstrb", {28'd0, mem_wstrb}, {28'd0, vecs[i].exp_strb});
         check("tbl_dbg_pc", dbg_pc, 32'h0000_0100 + i);
         check_bit("tbl_busy", sq_empty, 1'b0);
         tick();
         tick();
         check_bit("tbl_empty_3cyc", sq_empty, 1'b1);
         sb_check();
      end

      // Back-pressure: fill the queue while the bus refuses requests.
      aw_ok   = 1'b0;
      b_delay = 1;
      tick();
      enq(`YSYX_WSTRB_SW, 32'h8000_0010, 32'hD000_0000, 32'h0000_1000, '{32'h8000_0010, 32'hD000_0000, 4'b1111});
      enq(`YSYX_WSTRB_SB, 32'h8000_0021, 32'h0000_0077, 32'h0000_1004, '{32'h8000_0020, 32'h7777_7777, 4'b0010});
      enq(`YSYX_WSTRB_SH, 32'h8000_0032, 32'h0000_1234, 32'h0000_1008, '{32'h8000_0030, 32'h1234_1234, 4'b1100});
      enq(`YSYX_WSTRB_SW, 32'h8000_0044, 32'h4444_0001, 32'h0000_100C, '{32'h8000_0044, 32'h4444_0001, 4'b1111});
      check_bit("full_ready", sq_ready, 1'b0);
      check_bit("full_awvalid", mem_awvalid, 1'b1);
      check("full_awaddr", mem_awaddr, 32'h8000_0010);
      check("full_dbg_pc", dbg_pc, 32'h0000_1000);
      ld_addr = 32'h8000_0013;
      #1;
      check_bit("ld_same_word", ld_conflict, 1'b1);
      ld_addr = 32'h8000_0014;
      #1;
      check_bit("ld_next_word", ld_conflict, 1'b0);
      ld_addr = 32'h8000_0013;
      tick();
      tick();
      check_bit("hold_awvalid", mem_awvalid, 1'b1);
      check("hold_awaddr", mem_awaddr, 32'h8000_0010);
      check("hold_wdata", mem_wdata, 32'hD000_0000);
      check("hold_wstrb", {28'd0, mem_wstrb}, 32'h0000_000F);

      // Release the bus: accepted at the next edge, response two cycles later.
      aw_ok = 1'b1;
      tick();
      check_bit("acc_awvalid", mem_awvalid, 1'b0);
      check_bit("acc_ready", sq_ready, 1'b0);
      tick();
      check_bit("resp_ready", sq_ready, 1'b0);
      check_bit("resp_conflict", ld_conflict, 1'b1);
      tick();
      check_bit("pop_ready", sq_ready, 1'b1);
      check_bit("pop_conflict", ld_conflict, 1'b0);
      wait_empty(80);
      sb_check();

      // Reset while a response is outstanding with a second entry queued.
      b_delay = 6;
      enq(`YSYX_WSTRB_SW, 32'h8000_0050, 32'h5050_5050, 32'h0000_2000, '{32'h8000_0050, 32'h5050_5050, 4'b1111});
      enq(`YSYX_WSTRB_SW, 32'h8000_0060, 32'h6060_6060, 32'h0000_2004, '{32'h8000_0060, 32'h6060_6060, 4'b1111});
      check_bit("mid_awvalid", mem_awvalid, 1'b0);
      check_bit("mid_busy", sq_empty, 1'b0);
      ld_addr = 32'h8000_0060;
      bus_en  = 1'b0;
      reset   = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      obs_q.delete();
      check_bit("mrst_awvalid", mem_awvalid, 1'b0);
      check("mrst_awaddr", mem_awaddr, 32'h0);
      check("mrst_wdata", mem_wdata, 32'h0);
      check("mrst_wstrb", {28'd0, mem_wstrb}, 32'h0);
      check_bit("mrst_ready", sq_ready, 1'b1);
      check_bit("mrst_empty", sq_empty, 1'b1);
      check_bit("mrst_conflict", ld_conflict, 1'b0);
      check("mrst_dbg_pc", dbg_pc, 32'h0);
      force_b = 1'b1;
      tick();
      force_b = 1'b0;
      tick();
      check_bit("stray_b_empty", sq_empty, 1'b1);
      check_bit("stray_b_ready", sq_ready, 1'b1);
      check_bit("stray_b_awvalid", mem_awvalid, 1'b0);

      // The queue works again from the reset pointers.
      bus_en  = 1'b1;
      b_delay = 0;
      tick();
      enq(`YSYX_WSTRB_SW, 32'h8000_0070, 32'h7070_7070, 32'h0000_3000, '{32'h8000_0070, 32'h7070_7070, 4'b1111});
      check("post_dbg_pc", dbg_pc, 32'h0000_3000);
      wait_empty(40);
      sb_check();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_squ.md
Name: ysyx_squ

Overview:
- Store queue unit. It receives committed stores from the reorder unit's commit port, which carries store, alu, sq_waddr, sq_wdata, pc and valid, and returns sq_ready to it.
- It buffers stores in program order and drains them one at a time to the data-memory write channel.
- It reports whether a pending store overlaps a load's word so the LSU can stall the load. It reports empty so fence.i and fence_time can wait for drain.
- Committed stores are architectural state: pipe flushes never discard queue contents.

Parameters:
- SQ_SIZE, 4, queue depth in entries; power of two, at least 2.
- XLEN, `YSYX_XLEN, address and data width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cm_valid  in  1  reorder unit retires the head entry this cycle.
- cm_store  in  1  the retiring entry is a store.
- cm_alu  in  5  store size code: `YSYX_WSTRB_SB, `YSYX_WSTRB_SH or `YSYX_WSTRB_SW.
- cm_waddr  in  XLEN  store byte address.
- cm_wdata  in  XLEN  store data, right-aligned (not lane-shifted).
- cm_pc  in  XLEN  store PC, kept for debug and trace only.
- sq_ready  out  1  queue can accept one store this cycle.
- sq_empty  out  1  no entry valid and drain FSM idle.
- mem_awvalid  out  1  write request valid.
- mem_awaddr  out  XLEN  word-aligned address ({waddr[XLEN-1:2],2'b00}).
- mem_wdata  out  XLEN  lane-shifted data.
- mem_wstrb  out  4  byte strobes.
- mem_awready  in  1  write request accepted.
- mem_bvalid  in  1  write response; always accepted, no bready.
- ld_addr  in  XLEN  address of a load probing the queue.
- ld_conflict  out  1  a valid entry has the same word address as ld_addr.
- dbg_pc  out  XLEN  PC of the entry being drained.

Behaviour:
- Storage: circular buffer with head, tail and count registers, each $clog2(SQ_SIZE)+1 bits wide where needed.
- Entry contents: per-entry valid, word address, shifted data, wstrb and pc.
- Enqueue condition: cm_valid && cm_store && sq_ready. On enqueue, write the entry at tail, set its valid bit, and advance tail with modulo wrap.
- If cm_valid && cm_store arrives while sq_ready=0, it is a protocol violation; the bench asserts it never happens.
- Size decode:
  - SB: wstrb=4'b0001<<a; wdata={4{wdata[7:0]}}.
  - SH: wstrb=4'b0011<<a; wdata={2{wdata[15:0]}}.
  - SW: wstrb=4'b1111; wdata unchanged.
  - a=cm_waddr[1:0]. Misalignment has already trapped upstream, so it is not checked here.
  - Any other code enqueues with wstrb=0; the drain still performs the bus transaction.
- sq_ready = (count != SQ_SIZE). It is registered-state only, with no combinational path from cm_valid, mem_awready or mem_bvalid.
  - Consequence: when full, it stays 0 in the cycle a pop occurs and rises the cycle after.
- Drain FSM states are IDLE, REQ and RESP.
  - IDLE -> REQ when the head entry is valid. An entry enqueued in cycle N is first presented in cycle N+1.
  - REQ: mem_awvalid=1 with the head entry's address, data and strobes, all held stable. REQ -> RESP when mem_awready=1.
  - RESP: mem_awvalid=0. When mem_bvalid=1, clear the head valid bit, advance head with wrap, decrement count, and go to IDLE.
  - Minimum occupancy per store is 3 cycles: IDLE, REQ and RESP, with awready and bvalid each asserted immediately.
- mem_bvalid outside RESP is ignored.
- Simultaneous enqueue and pop: count unchanged, head and tail both advance.
- Enqueuing into an empty queue while the FSM is in RESP for the last entry is legal; the new entry drains next.
- ld_conflict: OR over all valid entries of (entry.addr[XLEN-1:2] == ld_addr[XLEN-1:2]). It is purely combinational.
  - The entry currently in REQ or RESP still counts until popped.
  - An entry being enqueued this cycle is not yet visible.
- sq_empty = (count==0) && (state==IDLE).
- dbg_pc = pc at head.
- Reset (synchronous, at any point including mid-REQ or mid-RESP):
  - head, tail and count go to 0; all valid bits clear; FSM goes to IDLE.
  - Outputs after reset: mem_awvalid=0, mem_awaddr=0, mem_wdata=0, mem_wstrb=0, sq_ready=1, sq_empty=1, ld_conflict=0, dbg_pc=0.
  - Any outstanding bus response is dropped; the system resets the bus as well.
- No flush input. Flush and fence_time at the reorder unit do not affect this block.

Test Plan:
- Reset, then SW to 0x8000_0004 with data 0x1122_3344, awready and bvalid asserted immediately.
  -> Next cycle mem_awvalid=1, awaddr=0x8000_0004, wdata=0x1122_3344, wstrb=4'b1111.
  -> sq_empty returns to 1 three cycles after enqueue.
- SB to 0x8000_0003 with data 0xAB -> wstrb=4'b1000, wdata=0xABAB_ABAB.
- SH to 0x8000_0002 with data 0xBEEF -> wstrb=4'b1100, wdata=0xBEEF_BEEF.
- Hold awready=0 and enqueue 4 stores.
  -> sq_ready=0 after the 4th enqueue; awvalid and address stay stable.
  -> Release awready; bvalid arrives 2 cycles after acceptance; sq_ready=1 the cycle after the first pop.
  -> All four are drained in FIFO order, with correct wrap of head and tail.
- Queue holds an entry at 0x8000_0010.
  -> ld_addr=0x8000_0013 gives ld_conflict=1; ld_addr=0x8000_0014 gives 0.
  -> ld_conflict=0 once that entry is popped.
- Assert reset while in RESP with 2 entries queued -> next cycle all outputs at their reset values; the following bvalid is ignored.
